// File: rtl/qam_pkg.sv
// qam_pkg: shared types and Gray level constants for the 16-QAM
// symbol scheduler slice.
package qam_pkg;

  localparam int SYM_W   = 4;
  localparam int LEVEL_W = 3;

  localparam logic [LEVEL_W-1:0] L_M3 = 3'b101;
  localparam logic [LEVEL_W-1:0] L_M1 = 3'b111;
  localparam logic [LEVEL_W-1:0] L_P1 = 3'b001;
  localparam logic [LEVEL_W-1:0] L_P3 = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [SYM_W-1:0] data;
    logic             last;
  } sym_t;

endpackage

// File: rtl/qam_symbol_sched_if.sv
// qam_symbol_sched_if: valid/ready symbol stream from the bit framer
// into the QAM symbol scheduler.
interface qam_symbol_sched_if;
  import qam_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [SYM_W-1:0] s_data;
  logic             s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/qam_gray_map.sv
// qam_gray_map: 2-bit Gray code to signed 3-bit amplitude level
// for one axis of the 16-QAM constellation.
module qam_gray_map
  import qam_pkg::*;
(
  input  logic [1:0]         i_bits,
  output logic [LEVEL_W-1:0] o_level
);

  always_comb begin
    o_level = L_M3;
    unique case (i_bits)
      2'b00: o_level = L_M3;
      2'b01: o_level = L_M1;
      2'b11: o_level = L_P1;
      2'b10: o_level = L_P3;
    endcase
  end

endmodule

// File: rtl/qam_symbol_sched.sv
// qam_symbol_sched: 16-QAM symbol-rate scheduler driving the sin_cos NCO.
// Optional QAM_PREAMBLE_EN inserts an alternating preamble after idle.
module qam_symbol_sched
  import qam_pkg::*;
#(
  parameter int SAMPLES_PER_SYM = 32,
  parameter int CNT_W           = 5,
`ifdef QAM_PREAMBLE_EN
  parameter int PREAMBLE_SYMS   = 4,
`endif
  parameter int UNDERRUN_W      = 8
) (
  input  logic                       Clk,
  input  logic                       reset,
  qam_symbol_sched_if.slave          s,
  output logic                       nco_en,
  output logic                       nco_phase_rst,
  output logic signed [LEVEL_W-1:0]  i_level,
  output logic signed [LEVEL_W-1:0]  q_level,
  output logic                       sym_valid,
  output logic                       sym_start,
  output logic                       frame_done,
  output logic [UNDERRUN_W-1:0]      underrun_cnt
);

  localparam logic [CNT_W-1:0] CNT_END =
    CNT_W'(SAMPLES_PER_SYM - 1);

  state_e                r_state;
  state_e                w_state_n;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_n;
  sym_t                  r_cur;
  sym_t                  w_cur_n;
  sym_t                  r_nxt;
  sym_t                  w_nxt_n;
  logic                  r_nxt_full;
  logic                  w_nxt_full_n;
  logic [UNDERRUN_W-1:0] r_under;
  logic [UNDERRUN_W-1:0] w_under_n;
  logic                  w_fd_n;

  logic                  r_s_ready;
  logic                  r_nco_en;
  logic                  r_phase_rst;
  logic                  r_sym_valid;
  logic                  r_sym_start;
  logic                  r_fd;
  logic [LEVEL_W-1:0]    r_i;
  logic [LEVEL_W-1:0]    r_q;

  logic                  w_hs;
  logic                  w_end;
  sym_t                  w_in;
  logic                  w_run_n;
  logic [LEVEL_W-1:0]    w_i_map;
  logic [LEVEL_W-1:0]    w_q_map;
  logic [LEVEL_W-1:0]    w_i_n;
  logic [LEVEL_W-1:0]    w_q_n;

`ifdef QAM_PREAMBLE_EN
  localparam int PRE_W = $clog2(PREAMBLE_SYMS + 1);

  // r_pre counts preamble symbols still to send, r_pre_neg picks -3/-3
  logic [PRE_W-1:0]      r_pre;
  logic [PRE_W-1:0]      w_pre_n;
  logic                  r_pre_neg;
  logic                  w_pre_neg_n;
  logic                  r_from_idle;
  logic                  w_from_idle_n;
`endif

  assign w_hs  = s.s_valid && !r_nxt_full;
  assign w_end = (r_cnt == CNT_END);
  assign w_in  = '{data: s.s_data, last: s.s_last};

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_cur_n      = r_cur;
    w_nxt_n      = r_nxt;
    w_nxt_full_n = r_nxt_full;
    w_under_n    = r_under;
    w_fd_n       = 1'b0;
`ifdef QAM_PREAMBLE_EN
    w_pre_n       = r_pre;
    w_pre_neg_n   = r_pre_neg;
    w_from_idle_n = r_from_idle;
`endif
    if (w_hs) begin
      w_nxt_n      = w_in;
      w_nxt_full_n = 1'b1;
    end
    unique case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_state_n = ST_LOAD;
`ifdef QAM_PREAMBLE_EN
          w_from_idle_n = 1'b1;
`endif
        end
      end
      ST_GAP: begin
        if (w_hs) begin
          w_state_n = ST_LOAD;
`ifdef QAM_PREAMBLE_EN
          w_from_idle_n = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        w_cur_n      = r_nxt;
        w_nxt_full_n = 1'b0;
        w_cnt_n      = '0;
        w_state_n    = ST_RUN;
`ifdef QAM_PREAMBLE_EN
        if (r_from_idle) begin
          w_pre_n     = PRE_W'(PREAMBLE_SYMS);
          w_pre_neg_n = 1'b0;
        end
`endif
      end
      ST_RUN: begin
        if (!w_end) begin
          w_cnt_n = r_cnt + 1'b1;
        end else begin
          w_cnt_n = '0;
`ifdef QAM_PREAMBLE_EN
          if (r_pre != '0) begin
            w_pre_n     = r_pre - 1'b1;
            w_pre_neg_n = !r_pre_neg;
          end else
`endif
          if (r_nxt_full) begin
            w_cur_n      = r_nxt;
            w_nxt_full_n = 1'b0;
          end else if (w_hs) begin
            // bypass: symbol arrives on the last sample, no gap
            w_cur_n      = w_in;
            w_nxt_full_n = 1'b0;
          end else if (r_cur.last) begin
            w_fd_n    = 1'b1;
            w_state_n = ST_IDLE;
          end else begin
            if (r_under != '1) begin
              w_under_n = r_under + 1'b1;
            end
            w_state_n = ST_GAP;
          end
        end
      end
    endcase
  end

  qam_gray_map u_map_i (
    .i_bits  (w_cur_n.data[3:2]),
    .o_level (w_i_map)
  );

  qam_gray_map u_map_q (
    .i_bits  (w_cur_n.data[1:0]),
    .o_level (w_q_map)
  );

  assign w_run_n = (w_state_n == ST_RUN);

  always_comb begin
    w_i_n = '0;
    w_q_n = '0;
    if (w_run_n) begin
      w_i_n = w_i_map;
      w_q_n = w_q_map;
`ifdef QAM_PREAMBLE_EN
      if (w_pre_n != '0) begin
        w_i_n = w_pre_neg_n ? L_M3 : L_P3;
        w_q_n = w_pre_neg_n ? L_M3 : L_P3;
      end
`endif
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cur      <= '0;
      r_nxt      <= '0;
      r_nxt_full <= 1'b0;
      r_under    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_cur      <= w_cur_n;
      r_nxt      <= w_nxt_n;
      r_nxt_full <= w_nxt_full_n;
      r_under    <= w_under_n;
    end
  end

`ifdef QAM_PREAMBLE_EN
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_pre       <= '0;
      r_pre_neg   <= 1'b0;
      r_from_idle <= 1'b0;
    end else begin
      r_pre       <= w_pre_n;
      r_pre_neg   <= w_pre_neg_n;
      r_from_idle <= w_from_idle_n;
    end
  end
`endif

  // outputs are flops loaded from the next-state decode
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_s_ready   <= 1'b1;
      r_nco_en    <= 1'b0;
      r_phase_rst <= 1'b0;
      r_sym_valid <= 1'b0;
      r_sym_start <= 1'b0;
      r_fd        <= 1'b0;
      r_i         <= '0;
      r_q         <= '0;
    end else begin
      r_s_ready   <= !w_nxt_full_n;
      r_nco_en    <= w_run_n;
      r_phase_rst <= (w_state_n == ST_LOAD);
      r_sym_valid <= w_run_n;
      r_sym_start <= w_run_n && (w_cnt_n == '0);
      r_fd        <= w_fd_n;
      r_i         <= w_i_n;
      r_q         <= w_q_n;
    end
  end

  assign s.s_ready     = r_s_ready;
  assign nco_en        = r_nco_en;
  assign nco_phase_rst = r_phase_rst;
  assign sym_valid     = r_sym_valid;
  assign sym_start     = r_sym_start;
  assign frame_done    = r_fd;
  assign i_level       = r_i;
  assign q_level       = r_q;
  assign underrun_cnt  = r_under;

endmodule

// File: tb/tb_qam_symbol_sched.sv
// tb_qam_symbol_sched: randomized scoreboard bench for the QAM symbol
// scheduler (default build, preamble disabled).
module tb_qam_symbol_sched;

  localparam int SPS = 32;

  logic              Clk   = 1'b0;
  logic              reset = 1'b0;
  logic              nco_en;
  logic              nco_phase_rst;
  logic signed [2:0] i_level;
  logic signed [2:0] q_level;
  logic              sym_valid;
  logic              sym_start;
  logic              frame_done;
  logic [7:0]        underrun_cnt;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] d;
    logic       last;
    logic       prst;
    int         start;
  } exp_t;

  exp_t sb_q[$];

  // driver-side model: last accepted symbol's final sample cycle
  int m_end   = 0;
  int m_start = 0;
  bit m_prev  = 0;

  qam_symbol_sched_if sif ();

  qam_symbol_sched #(
    .SAMPLES_PER_SYM (SPS),
    .CNT_W           (5),
    .UNDERRUN_W      (8)
  ) dut (
    .Clk           (Clk),
    .reset         (reset),
    .s             (sif),
    .nco_en        (nco_en),
    .nco_phase_rst (nco_phase_rst),
    .i_level       (i_level),
    .q_level       (q_level),
    .sym_valid     (sym_valid),
    .sym_start     (sym_start),
    .frame_done    (frame_done),
    .underrun_cnt  (underrun_cnt)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Gray -> binary index b, amplitude = 2b-3
  function automatic logic [2:0] lvl(input logic [1:0] g);
    int b;
    b = 2 * int'(g[1]) + int'(g[1] ^ g[0]);
    return 3'(2 * b - 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  // scoreboard monitor
  initial begin : mon
    exp_t        cur;
    int          rem;
    bit          ended;
    bit          elast;
    int          eu;
    bit          starting;
    bit          efd;
    bit          eprst;
    logic [10:0] got_v;
    logic [10:0] exp_v;
    rem   = 0;
    ended = 0;
    elast = 0;
    eu    = 0;
    cur   = '{d: 4'h0, last: 1'b0, prst: 1'b0, start: 0};
    forever begin
      @(negedge Clk or negedge reset);
      if (!reset) begin
        #1;
        chk("reset_outs",
            {sif.s_ready, underrun_cnt, sym_valid, nco_en, sym_start,
             nco_phase_rst, frame_done, i_level, q_level},
            {1'b1, 19'd0});
        sb_q.delete();
        rem   = 0;
        ended = 0;
        eu    = 0;
      end else begin
        starting = (sb_q.size() > 0) && (sb_q[0].start == cyc);
        efd = 0;
        if (ended) begin
          if (!starting) begin
            if (elast) efd = 1;
            else if (eu < 255) eu++;
          end
          ended = 0;
        end
        if (starting) begin
          cur = sb_q.pop_front();
          rem = SPS;
        end
        eprst = (sb_q.size() > 0) && sb_q[0].prst &&
                (sb_q[0].start == cyc + 1);
        got_v = {sym_valid, nco_en, sym_start, nco_phase_rst,
                 frame_done, i_level, q_level};
        if (rem > 0)
          exp_v = {1'b1, 1'b1, starting, eprst, efd,
                   lvl(cur.d[3:2]), lvl(cur.d[1:0])};
        else
          exp_v = {1'b0, 1'b0, 1'b0, eprst, efd, 6'd0};
        chk("outs", 32'(got_v), 32'(exp_v));
        chk("underrun_cnt", 32'(underrun_cnt), 32'(eu));
        if (rem > 0) begin
          rem--;
          if (rem == 0) begin
            ended = 1;
            elast = cur.last;
          end
        end
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic l);
    int   n;
    exp_t e;
    n = 0;
    @(negedge Clk);
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = l;
    while (!sif.s_ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (!sif.s_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      sif.s_valid = 1'b0;
      return;
    end
    e.d    = d;
    e.last = l;
    if (m_prev && cyc <= m_end) begin
      e.start = m_end + 1;
      e.prst  = 1'b0;
    end else begin
      e.start = cyc + 2;
      e.prst  = 1'b1;
    end
    m_start = e.start;
    m_end   = e.start + SPS - 1;
    m_prev  = 1;
    sb_q.push_back(e);
  endtask

  // idle until the next send presents its symbol in cycle c
  task automatic wait_to(input int c);
    do begin
      @(negedge Clk);
      sif.s_valid = 1'b0;
    end while (cyc < c - 1);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s1;
    int g;
    sif.s_valid = 1'b0;
    sif.s_data  = 4'h0;
    sif.s_last  = 1'b0;
    repeat (3) @(negedge Clk);
    #2 reset = 1'b1;

    // single symbol, last
    send(4'b1000, 1'b1);
    wait_to(m_end + 4);

    // back-to-back frame of three
    send(4'b0000, 1'b0);
    s1 = m_start;
    send(4'b0111, 1'b0);
    send(4'b1110, 1'b1);
    chk("nxt_full_stall", 32'(cyc), 32'(s1 + SPS));
    wait_to(m_end + 4);

    // bypass on the last sample
    send(4'b0101, 1'b0);
    wait_to(m_end);
    send(4'b1010, 1'b1);
    wait_to(m_end + 4);

    // mid-frame stall
    send(4'b0011, 1'b0);
    wait_to(m_end + 11);
    send(4'b1100, 1'b1);
    wait_to(m_end + 4);

    // randomized traffic
    for (int k = 0; k < 80; k++) begin
      g = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 45);
      if (g > 0) wait_to(cyc + g);
      send(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end
    wait_to(m_end + 4);

    // drive the underrun counter into saturation
    for (int k = 0; k < 300; k++) begin
      send(4'($urandom_range(0, 15)), 1'b0);
      wait_to(m_end + 2);
    end
    send(4'b1001, 1'b1);
    wait_to(m_end + 4);

    // asynchronous reset in the middle of a symbol
    send(4'b0110, 1'b0);
    wait_to(m_start + 15);
    @(posedge Clk);
    #2 reset = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    m_prev = 0;
    #2 reset = 1'b1;
    send(4'b1011, 1'b1);
    wait_to(m_end + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qam_symbol_sched.md
Name: qam_symbol_sched

Overview:
- Symbol-rate controller for the 16-QAM transmit path.
- Accepts 4-bit symbols over a valid/ready stream and Gray-maps each one to signed I/Q amplitude levels.
- Holds each symbol for exactly SAMPLES_PER_SYM carrier samples and sequences the sin_cos carrier generator's enable and phase reset, so the I/Q mixer sees symbol-aligned carrier cycles.
- Sits between the bit framer and the sin_cos plus mixer datapath.

Parameters:
- SAMPLES_PER_SYM, 32, carrier samples (Clk cycles) per symbol, >=2
- CNT_W, 5, width of sample counter; must satisfy 2**CNT_W >= SAMPLES_PER_SYM
- UNDERRUN_W, 8, width of saturating underrun counter
- PREAMBLE_SYMS, 4, preamble length in symbols (used only with the optional feature)

Ports:
- Clk, input, 1, system clock; all state on rising edge
- reset, input, 1, asynchronous active-low reset
- s_valid, input, 1, symbol available
- s_ready, output, 1, block can accept a symbol
- s_data, input, 4, symbol bits; [3:2] are I, [1:0] are Q
- s_last, input, 1, symbol is the last one of the frame
- nco_en, output, 1, enable to sin_cos generator
- nco_phase_rst, output, 1, one-cycle pulse that zeroes carrier phase
- i_level, output, 3, signed I amplitude in {-3,-1,+1,+3}, 0 when idle
- q_level, output, 3, signed Q amplitude, same encoding
- sym_valid, output, 1, levels are valid this cycle
- sym_start, output, 1, pulse on the first sample of each symbol
- frame_done, output, 1, pulse after the last sample of an s_last symbol
- underrun_cnt, output, UNDERRUN_W, saturating count of mid-frame starvation events

Behaviour:
- Reset (asynchronous, immediate, including mid-symbol):
  - State IDLE; holding register empty; sample_cnt 0.
  - All outputs 0 except s_ready=1.
- Gray mapping per axis: 00->-3, 01->-1, 11->+1, 10->+3.
- Storage: cur register (the symbol being transmitted) and a one-entry nxt holding register.
  - s_ready = !nxt_full.
  - Handshake = s_valid && s_ready.
- States IDLE, LOAD, RUN, GAP:
  - IDLE: on handshake, store the symbol in nxt; next cycle go to LOAD.
  - LOAD (1 cycle):
    - Move nxt to cur; nco_phase_rst=1; nco_en=0.
    - Levels still 0; sym_valid=0.
    - Next state RUN.
  - RUN:
    - nco_en=1, sym_valid=1, levels = map(cur).
    - sample_cnt runs 0..SAMPLES_PER_SYM-1; sym_start=1 when sample_cnt==0.
  - End of RUN, at sample_cnt==SAMPLES_PER_SYM-1, the first matching case applies:
    - (a) nxt full: cur<=nxt, sample_cnt<=0, stay in RUN. Seamless, no phase reset.
    - (b) nxt empty and handshake this cycle: the incoming symbol bypasses into cur. Seamless, same as (a).
    - (c) cur_last=1: frame_done=1; go to IDLE.
    - (d) Otherwise: underrun_cnt+1 (saturates at all-ones); go to GAP.
  - GAP:
    - Levels 0; nco_en=0; sym_valid=0.
    - On handshake, go to LOAD (phase re-aligned).
- Frame boundary: after an s_last symbol, a symbol already in nxt is still consumed via (a) with no phase reset; the frame_done pulse is suppressed in that case.
- nxt captures s_last together with s_data.
- Latency:
  - Handshake in IDLE at cycle t: LOAD at t+1, first sample (sym_start) at t+2.
  - Back-to-back symbols are spaced exactly SAMPLES_PER_SYM cycles apart.
- All outputs are registered.

Optional Feature:
- QAM_PREAMBLE_EN.
- Defined:
  - The first LOAD after IDLE (not after GAP) is followed by PREAMBLE_SYMS preamble symbols before cur is sent.
  - Preamble symbols alternate I/Q=(+3,+3) and (-3,-3), starting with (+3,+3).
  - Preamble symbols assert sym_start and sym_valid.
  - s_ready still follows nxt.
- Undefined: the preamble logic is absent and data follows LOAD directly.

Decomposition:
- Package qam_pkg:
  - state enum (IDLE, LOAD, RUN, GAP);
  - SYM_W=4 and LEVEL_W=3;
  - Gray level constants L_M3, L_M1, L_P1, L_P3.
- Sub-module qam_gray_map: pure 2-bit-to-level mapper, instantiated for I and Q.

Test Plan:
- Reset, then one symbol s_data=4'b1000, s_last=1 -> nco_phase_rst at t+1; 32 cycles of i=+3, q=-3; frame_done on the following cycle; return to IDLE.
- Three back-to-back symbols 0000, 0111, 1110 (last on the third) -> sym_start every 32 cycles; levels (-3,-3), (-1,+1), (+1,+3); only one nco_phase_rst; s_ready low while nxt is full.
- Symbol offered exactly at sample_cnt==31 with nxt empty -> bypass; no GAP; underrun_cnt stays 0.
- Feed stalls for 10 cycles mid-frame -> GAP with levels 0 and nco_en=0; underrun_cnt=1; resume goes through LOAD with a phase reset.
- Force 300 underruns with UNDERRUN_W=8 -> underrun_cnt holds at 255.
- Assert reset low at sample_cnt=15 -> all outputs 0 and s_ready=1 asynchronously; the next symbol restarts at LOAD.
- With QAM_PREAMBLE_EN, PREAMBLE_SYMS=4 -> four 32-cycle preamble symbols (+3,+3)/(-3,-3) before the first data symbol.
